// File: rtl/doc_uart_streamer.sv
// Streams the 16x32 document RAM out as 8N1 serial text, one CR LF terminated line per row
// with trailing blanks trimmed.
module doc_uart_streamer #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] read_data,
    output logic       read_en,
    output logic [8:0] read_addr,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int unsigned Cpb  = CLK_FREQ / BAUD;
    localparam int unsigned CntW = (Cpb > 1) ? $clog2(Cpb) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StLoad,
        StTx,
        StCr,
        StLf,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        row_q, row_d;
    logic [4:0]        col_q, col_d;
    logic [4:0]        last_q, last_d;
    logic              has_char_q, has_char_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [CntW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [3:0]        bit_idx_q, bit_idx_d;

    logic       in_frame;
    logic       bit_end;
    logic       frame_end;
    logic       cell_blank;
    logic [7:0] frame_data;
    logic [9:0] frame_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            row_q      <= '0;
            col_q      <= '0;
            last_q     <= '0;
            has_char_q <= 1'b0;
            shreg_q    <= '0;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            last_q     <= last_d;
            has_char_q <= has_char_d;
            shreg_q    <= shreg_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
        end
    end

    // Bit timing runs only while a frame is on the line and is parked at zero otherwise,
    // so every frame state starts with a fresh start bit.
    always_comb begin
        in_frame  = (state_q == StTx) || (state_q == StCr) || (state_q == StLf);
        bit_end   = (clk_cnt_q == CntW'(Cpb - 1));
        frame_end = in_frame && bit_end && (bit_idx_q == 4'd9);
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (in_frame) begin
            if (bit_end) begin
                bit_idx_d = frame_end ? 4'd0 : bit_idx_q + 4'd1;
            end else begin
                clk_cnt_d = clk_cnt_q + CntW'(1);
                bit_idx_d = bit_idx_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        last_d     = last_q;
        has_char_d = has_char_q;
        shreg_d    = shreg_q;
        cell_blank = (read_data == 8'h00) || (read_data == 8'h20);

        case (state_q)
            StIdle: begin
                if (send) begin
                    row_d      = '0;
                    col_d      = '0;
                    has_char_d = 1'b0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (!cell_blank) begin
                    last_d     = col_q;
                    has_char_d = 1'b1;
                end
                if (col_q == 5'd31) begin
                    if (has_char_d) begin
                        col_d   = '0;
                        state_d = StLoad;
                    end else begin
                        state_d = StCr;
                    end
                end else begin
                    col_d = col_q + 5'd1;
                end
            end
            StLoad: begin
                shreg_d = (read_data == 8'h00) ? 8'h20 : read_data;
                state_d = StTx;
            end
            StTx: begin
                if (frame_end) begin
                    if (col_q == last_q) begin
                        state_d = StCr;
                    end else begin
                        col_d   = col_q + 5'd1;
                        state_d = StLoad;
                    end
                end
            end
            StCr: begin
                if (frame_end) begin
                    state_d = StLf;
                end
            end
            StLf: begin
                if (frame_end) begin
                    if (row_q == 4'd15) begin
                        state_d = StFin;
                    end else begin
                        row_d      = row_q + 4'd1;
                        col_d      = '0;
                        has_char_d = 1'b0;
                        state_d    = StScan;
                    end
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        case (state_q)
            StCr:    frame_data = 8'h0D;
            StLf:    frame_data = 8'h0A;
            default: frame_data = shreg_q;
        endcase
        frame_bits = {1'b1, frame_data, 1'b0};
        tx         = in_frame ? frame_bits[bit_idx_q] : 1'b1;
        busy       = (state_q != StIdle);
        read_en    = busy;
        done       = (state_q == StFin);
        // The counters only move in SCAN/LOAD or on entry to them, so the address naturally
        // holds its last value elsewhere.
        read_addr  = {row_q, col_q};
    end

endmodule

// File: tb/tb_doc_uart_streamer.sv
// Bench for doc_uart_streamer: a UART monitor checks every received byte against a queue of
// expected bytes filled when each transfer is launched.
module tb_doc_uart_streamer;

    localparam int CPB   = 10;
    localparam int LIMIT = 20000;
    localparam int EMPTY_SPAN = 16 * (32 + 20 * CPB) + 2;

    logic       clk;
    logic       rst;
    logic       send;
    logic [7:0] read_data;
    logic       read_en;
    logic [8:0] read_addr;
    logic       busy;
    logic       done;
    logic       tx;

    logic [7:0] doc [0:511];
    logic [7:0] exp_q [$];

    int errors = 0;
    int checks = 0;

    assign read_data = doc[read_addr];

    doc_uart_streamer #(
        .CLK_FREQ(1000),
        .BAUD    (100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .send     (send),
        .read_data(read_data),
        .read_en  (read_en),
        .read_addr(read_addr),
        .busy     (busy),
        .done     (done),
        .tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // UART monitor: samples at the middle of each bit, reset aborts a partial frame.
    bit         m_act = 1'b0;
    int         m_cnt = 0;
    int         m_bi;
    logic [7:0] m_byte;
    logic [7:0] m_exp;

    always @(negedge clk) begin
        if (rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (tx === 1'b0) begin
                m_act = 1'b1;
                m_cnt = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt % CPB == CPB / 2) begin
                m_bi = m_cnt / CPB;
                if (m_bi == 0) begin
                    chk("start_bit", {31'd0, tx}, 32'd0);
                end else if (m_bi <= 8) begin
                    m_byte[m_bi-1] = tx;
                end else begin
                    chk("stop_bit", {31'd0, tx}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_extra: got byte %02h, expected no byte", m_byte);
                    end else begin
                        m_exp = exp_q.pop_front();
                        chk("rx_byte", {24'd0, m_byte}, {24'd0, m_exp});
                    end
                    m_act = 1'b0;
                end
            end
        end
    end

    // Reference: trim trailing blanks (0x00/0x20), map 0x00 to space, end each row with CR LF.
    task automatic push_doc_expected();
        int   last;
        logic [7:0] b;
        for (int r = 0; r < 16; r++) begin
            last = -1;
            for (int c = 0; c < 32; c++) begin
                b = doc[r*32+c];
                if (b != 8'h00 && b != 8'h20) last = c;
            end
            for (int c = 0; c <= last; c++) begin
                b = doc[r*32+c];
                exp_q.push_back((b == 8'h00) ? 8'h20 : b);
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic clear_doc();
        for (int i = 0; i < 512; i++) doc[i] = 8'h00;
    endtask

    // Launch one transfer; k counts negedges after the send pulse (k=1 is the first busy cycle).
    task automatic run_xfer(input int rep_k, output int span, output int first_start,
                            output int dones, output int done_k);
        span        = -1;
        first_start = -1;
        dones       = 0;
        done_k      = -1;
        send        = 1'b1;
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                done_k = k;
            end
            if (tx === 1'b0 && first_start < 0) first_start = k;
            if (busy !== 1'b1) begin
                span = k;
                break;
            end
            send = (k == rep_k);
        end
        send = 1'b0;
        if (span < 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: got busy still high, expected idle within %0d", LIMIT);
        end
        repeat (20) @(negedge clk);
        chk("exp_queue_drained", exp_q.size(), 32'd0);
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [8];
    int   span, fs, dones, dk;

    initial begin
        tbl[0] = '{8'h00, 8'h20};
        tbl[1] = '{8'h20, 8'h20};
        tbl[2] = '{8'h41, 8'h41};
        tbl[3] = '{8'h7F, 8'h7F};
        tbl[4] = '{8'hFF, 8'hFF};
        tbl[5] = '{8'h0D, 8'h0D};
        tbl[6] = '{8'h01, 8'h01};
        tbl[7] = '{8'h80, 8'h80};

        rst  = 1'b1;
        send = 1'b0;
        clear_doc();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_read_en", {31'd0, read_en}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_read_addr", {23'd0, read_addr}, 32'd0);

        // Empty document: 16 x CRLF, fixed span.
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
        run_xfer(-1, span, fs, dones, dk);
        chk("empty_span", span, EMPTY_SPAN);
        chk("empty_dones", dones, 32'd1);
        chk("empty_done_k", dk, EMPTY_SPAN - 1);
        chk("empty_first_start", fs, 32'd33);

        // Table: each row r holds {vector byte, 'X'}, so both cells are always sent.
        clear_doc();
        for (int r = 0; r < 16; r++) begin
            if (r < 8) begin
                doc[r*32]   = tbl[r].din;
                doc[r*32+1] = 8'h58;
                exp_q.push_back(tbl[r].exp);
                exp_q.push_back(8'h58);
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
        run_xfer(-1, span, fs, dones, dk);
        chk("table_dones", dones, 32'd1);
        chk("table_first_start", fs, 32'd34);

        // Row 0 "HI", row 3 interior blanks, row 15 col 31 'Z'.
        clear_doc();
        doc[0]          = 8'h48;
        doc[1]          = 8'h49;
        doc[3*32]       = 8'h00;
        doc[3*32+4]     = 8'h41;
        doc[15*32+31]   = 8'h5A;
        push_doc_expected();
        chk("model_row0_H", {24'd0, exp_q[0]}, 32'h48);
        chk("model_len", exp_q.size(), 32'd71);
        run_xfer(-1, span, fs, dones, dk);
        chk("mix_dones", dones, 32'd1);
        chk("mix_first_start", fs, 32'd34);
        chk("mix_span", span, 32'd16 * 232 + 39 * (10 * CPB + 1) + 2);

        // Same document, send re-pulsed mid-transfer: identical output, one done.
        push_doc_expected();
        run_xfer(500, span, fs, dones, dk);
        chk("repulse_dones", dones, 32'd1);
        chk("repulse_span", span, 32'd16 * 232 + 39 * (10 * CPB + 1) + 2);

        // Reset in the middle of data bit 0 of 'H'.
        clear_doc();
        doc[0] = 8'h48;
        doc[1] = 8'h49;
        send   = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (47) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_read_addr", {23'd0, read_addr}, 32'd0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst   = 1'b0;
        dones = 0;
        span  = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (busy === 1'b1) span++;
        end
        chk("post_rst_no_done", dones, 32'd0);
        chk("post_rst_idle", span, 32'd0);
        push_doc_expected();
        run_xfer(-1, span, fs, dones, dk);
        chk("restart_dones", dones, 32'd1);
        chk("restart_first_start", fs, 32'd34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/doc_uart_streamer.md
# doc_uart_streamer

Downstream consumer of the 512-cell document RAM (16 rows × 32 columns, one byte per cell). On a `send` pulse it walks the document row by row and transmits it as 8N1 serial text on `tx`. Each row has its trailing blanks trimmed and is terminated with CR LF. It owns the document read port while busy and releases it when the transfer completes.

## Interface
Parameters:
- CLK_FREQ, 100_000_000: clk frequency in Hz.
- BAUD, 115200: serial bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (868 at defaults).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- send  input  1  start request, one-cycle pulse; ignored unless idle.
- read_data  input  8  document byte at read_addr; asynchronous read, valid in the same cycle.
- read_en  output  1  read-port ownership request to the editor mux; equals busy.
- read_addr  output  9  document address {row[3:0], col[4:0]}.
- busy  output  1  high from the cycle after an accepted send through the done cycle.
- done  output  1  one-cycle pulse after the final LF stop bit.
- tx  output  1  serial line; idles high.

## Operation
- Blank cell: byte 0x00 or 0x20. A 0x00 cell is transmitted as 0x20. All other bytes are transmitted unchanged.
- States: IDLE, SCAN, LOAD, TX, CR, LF, FIN.
- IDLE: tx=1, busy=0. When send=1, clear row and col, set has_char=0, and go to SCAN.
- SCAN: read_addr={row,col}, one cell per cycle, col 0..31. If the cell is non-blank, record last=col and set has_char=1. After col 31:
  - has_char=1: clear col and go to LOAD.
  - has_char=0: go to CR.
- LOAD: read_addr={row,col}. Latch the mapped byte into the shift register, then go to TX.
- TX: shift out the frame LSB-first. Frame = start bit 0, data[0..7], stop bit 1. Each bit lasts CLKS_PER_BIT cycles. At the end of the stop bit:
  - col==last: go to CR.
  - otherwise: col+1, go to LOAD.
- CR: transmit a 0x0D frame (same framer as TX). Then go to LF.
- LF: transmit a 0x0A frame. Then:
  - row==15: go to FIN.
  - otherwise: row+1, col=0, has_char=0, go to SCAN.
- FIN: done=1 for one cycle, busy remains 1. Next state IDLE.
- Row and col are 4-bit and 5-bit counters. No wrap-around occurs because the terminal conditions are checked before increment.
- An interior blank (before `last`) is sent as 0x20. Only trailing blanks are trimmed.
- An empty document produces exactly 32 bytes: 16 × "\r\n".
- send while busy: ignored, with no queuing.
- rst at any point, including mid-frame: the next cycle enters IDLE with tx=1, busy=0, done=0, and all counters cleared. A truncated frame is acceptable.
- The document may change during transfer. Each byte is sampled at its LOAD cycle, so the scan result and the sent data may disagree. This is accepted behaviour.

## Timing
- Reset values: tx=1, busy=0, read_en=0, done=0, read_addr=0.
- Accepted send at cycle t: busy=1 from t+1, first SCAN address at t+1.
- Start bit of the first row byte falls at t+1+32+1: 32 scan cycles, then 1 LOAD cycle.
- Byte-to-byte gap: one LOAD cycle between a stop bit and the next start bit. CR and LF frames follow with no gap.
- A frame occupies exactly 10×CLKS_PER_BIT cycles, and the bit counter reloads on each bit boundary.
- Row cost: 32 + n×(10×CPB+1) + 20×CPB cycles, where n = last+1 (0 for an empty row).
- done asserts the cycle after the last LF stop-bit period ends. busy falls together with the done pulse's return to IDLE, on the following cycle.
- read_addr is meaningful only in the SCAN and LOAD states. In other states it holds its last value.

## Test plan
Simulate with CLK_FREQ=1000, BAUD=100 (CPB=10), using a UART monitor model.
- All-zero document, send pulse → 32 bytes, alternating 0x0D/0x0A. A single done pulse. busy high for exactly 16×(32+200)+2 cycles.
- Row 0 = "HI" at cols 0-1, rest blank → first bytes 0x48 0x49 0x0D 0x0A, then 15 × CRLF.
- Row 3: cell 0 = 0x00, cell 4 = 'A' → row 3 is sent as 20 20 20 20 41 0D 0A (interior blanks kept, tail trimmed).
- Row 15, col 31 = 'Z', rest blank → the final output line is 31 × 0x20, 0x5A, 0x0D, 0x0A.
- send re-pulsed mid-transfer → output is identical to an undisturbed run, with exactly one done pulse.
- rst asserted in the middle of a data bit → tx=1 and busy=0 on the next cycle, and no done. A fresh send then restarts from row 0.
